patdet_prog: RTL and testbench

Programmable serial pattern detector: a runtime-loaded bit pattern of 1..MAX_LEN bits is matched against a serial input stream qualified by a valid strobe. Overlapping or non-overlapping matching is selectable at load time, and an optional saturating match counter can be compiled in. It replaces fixed-pattern detector FSMs in the serial front-end, and one instance covers any pattern up to MAX_LEN bits.

---
 rtl/patdet_pkg.sv | 28 ++
 rtl/patdet_sat_cnt.sv | 23 ++
 rtl/patdet_prog.sv | 109 ++++++++++
 tb/tb_patdet_prog.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/patdet_pkg.sv
// patdet_pkg: shared types and helpers for the programmable pattern detector.
// State encoding, LEN_W derivation and the len-bit compare mask builder.
package patdet_pkg;

   typedef enum logic [1:0] {
      PD_UNCFG,
      PD_FILL,
      PD_RUN
   } pd_state_t;

   // Widest pattern the mask helper can describe.
   localparam int PD_MASK_W = 64;

   // Width needed to hold a length of 0..max_len inclusive.
   function automatic int pd_len_w(input int max_len);
      return $clog2(max_len) + 1;
   endfunction

   // Ones in the low len bits, zeros above: selects the live pattern bits.
   function automatic logic [PD_MASK_W-1:0] pd_len_mask(input int len);
      logic [PD_MASK_W-1:0] m;
      m = '0;
      for (int i = 0; i < PD_MASK_W; i++)
         m[i] = (i < len);
      return m;
   endfunction

endpackage

// File: rtl/patdet_sat_cnt.sv
// patdet_sat_cnt: W-bit up counter that sticks at all-ones.
// Synchronous clear; a clear together with an increment yields 1.
module patdet_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count increments, saturating; clear restarts the count.
   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (clr)
         count <= inc ? W'(1) : '0;
      else if (inc && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/patdet_prog.sv
// patdet_prog: runtime-programmable serial pattern detector.
// Define PATDET_COUNT_EN to build in the saturating match counter.
module patdet_prog
   import patdet_pkg::*;
#(
   parameter  int MAX_LEN = 8,
   parameter  int CNT_W   = 16,
   localparam int LEN_W   = pd_len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               in_valid,
   input  logic               in_bit,
   input  logic               count_clr,
   output logic               match,
   output logic               cfg_err,
   output logic [CNT_W-1:0]   match_count
);

   pd_state_t          st_q;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               ovl_q;
   logic [MAX_LEN-1:0] hist_q;
   logic [LEN_W-1:0]   fill_q;

   logic               len_ok;
   logic               beat;
   logic [MAX_LEN-1:0] hist_n;
   logic [LEN_W-1:0]   fill_n;
   logic [MAX_LEN-1:0] mask;
   logic               full_n;
   logic               accept;

   // Next history/fill for a beat and whether that beat completes a match.
   always_comb begin
      len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
      beat   = in_valid && !cfg_load && (st_q != PD_UNCFG);
      hist_n = {hist_q[MAX_LEN-2:0], in_bit};
      fill_n = (fill_q == len_q) ? fill_q : fill_q + LEN_W'(1);
      mask   = MAX_LEN'(pd_len_mask(int'(len_q)));
      full_n = (fill_n == len_q);
      accept = beat && full_n && (((hist_n ^ pat_q) & mask) == '0);
   end

   // Configuration capture, beat tracking and registered pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         st_q    <= PD_UNCFG;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         hist_q  <= '0;
         fill_q  <= '0;
         match   <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         match   <= 1'b0;
         cfg_err <= 1'b0;
         if (cfg_load) begin
            hist_q <= '0;
            fill_q <= '0;
            if (len_ok) begin
               st_q  <= PD_FILL;
               pat_q <= cfg_pattern;
               len_q <= cfg_len;
               ovl_q <= cfg_overlap;
            end else begin
               st_q    <= PD_UNCFG;
               pat_q   <= '0;
               len_q   <= '0;
               ovl_q   <= 1'b0;
               cfg_err <= 1'b1;
            end
         end else if (beat) begin
            hist_q <= hist_n;
            match  <= accept;
            if (accept && !ovl_q) begin
               fill_q <= '0;
               st_q   <= PD_FILL;
            end else begin
               fill_q <= fill_n;
               st_q   <= full_n ? PD_RUN : PD_FILL;
            end
         end
      end
   end

`ifdef PATDET_COUNT_EN
   patdet_sat_cnt #(
      .W(CNT_W)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (count_clr),
      .inc   (accept),
      .count (match_count)
   );
`else
   logic unused_clr;
   assign unused_clr  = count_clr;
   assign match_count = '0;
`endif

endmodule

// File: tb/tb_patdet_prog.sv
// tb_patdet_prog: directed table plus randomized run against a stream model.
// Expected counter value follows PATDET_COUNT_EN.
module tb_patdet_prog;

   localparam int ML   = 8;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct {
      bit         rst;
      bit         load;
      logic [7:0] pat;
      logic [3:0] len;
      bit         ovl;
      bit         vld;
      bit         b;
      bit         clr;
      bit         em;
      bit         ee;
   } vec_t;

   logic          clk = 0;
   logic          reset;
   logic          cfg_load;
   logic [ML-1:0] cfg_pattern;
   logic [3:0]    cfg_len;
   logic          cfg_overlap;
   logic          in_valid;
   logic          in_bit;
   logic          count_clr;
   logic          match;
   logic          cfg_err;
   logic [CW-1:0] match_count;

   int nchk = 0;
   int nerr = 0;

   vec_t tbl[$];

   // model state: bits received since the last restart point
   bit         m_cfg;
   logic [7:0] m_pat;
   int         m_len;
   bit         m_ovl;
   bit         m_q[$];
   int         m_cnt;

   patdet_prog #(
      .MAX_LEN (ML),
      .CNT_W   (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .count_clr   (count_clr),
      .match       (match),
      .cfg_err     (cfg_err),
      .match_count (match_count)
   );

   always #5 clk = ~clk;

   task automatic add(input bit rst, input bit load, input logic [7:0] pat,
                      input logic [3:0] len, input bit ovl, input bit vld,
                      input bit b, input bit clr, input bit em, input bit ee);
      vec_t v;
      v.rst = rst; v.load = load; v.pat = pat; v.len = len; v.ovl = ovl;
      v.vld = vld; v.b = b; v.clr = clr; v.em = em; v.ee = ee;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: match when the last len received bits spell the pattern.
   task automatic model(input vec_t v, output bit em, output bit ee);
      bit hit;
      em = 0;
      ee = 0;
      if (v.rst) begin
         m_cfg = 0;
         m_len = 0;
         m_q.delete();
         m_cnt = 0;
         return;
      end
      if (v.load) begin
         m_q.delete();
         if (v.len >= 1 && int'(v.len) <= ML) begin
            m_cfg = 1;
            m_pat = v.pat;
            m_len = int'(v.len);
            m_ovl = v.ovl;
         end else begin
            m_cfg = 0;
            ee    = 1;
         end
      end else if (v.vld && m_cfg) begin
         m_q.push_back(v.b);
         if (m_q.size() > ML)
            void'(m_q.pop_front());
         if (m_q.size() >= m_len) begin
            hit = 1;
            for (int k = 0; k < m_len; k++)
               if (m_q[m_q.size() - 1 - k] != m_pat[k])
                  hit = 0;
            if (hit) begin
               em = 1;
               if (!m_ovl)
                  m_q.delete();
            end
         end
      end
`ifdef PATDET_COUNT_EN
      if (v.clr)
         m_cnt = em ? 1 : 0;
      else if (em && m_cnt < CMAX)
         m_cnt++;
`else
      m_cnt = 0;
`endif
   endtask

   task automatic drive(input vec_t v);
      reset       = v.rst;
      cfg_load    = v.load;
      cfg_pattern = v.pat;
      cfg_len     = v.len;
      cfg_overlap = v.ovl;
      in_valid    = v.vld;
      in_bit      = v.b;
      count_clr   = v.clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t       v;
      bit         em;
      bit         ee;
      logic [7:0] p8;

      reset = 1; cfg_load = 0; cfg_pattern = '0; cfg_len = '0;
      cfg_overlap = 0; in_valid = 0; in_bit = 0; count_clr = 0;
      m_cfg = 0; m_pat = '0; m_len = 0; m_ovl = 0; m_cnt = 0;

      // reset state and unconfigured stream
      add(1,0,8'h00,0,0,0,0,0, 0,0);
      add(0,0,8'h00,0,0,1,1,0, 0,0);
      add(0,0,8'h00,0,0,1,0,0, 0,0);
      // 1010 overlapping
      add(0,1,8'h0A,4,1,0,0,1, 0,0);
      add(0,0,8'h00,0,0,1,1,0, 0,0);
      add(0,0,8'h00,0,0,1,0,0, 0,0);
      add(0,0,8'h00,0,0,1,1,0, 0,0);
      add(0,0,8'h00,0,0,1,0,0, 1,0);
      add(0,0,8'h00,0,0,1,1,0, 0,0);
      add(0,0,8'h00,0,0,1,0,0, 1,0);
      // 1010 non-overlapping
      add(0,1,8'h0A,4,0,0,0,1, 0,0);
      for (int i = 0; i < 8; i++)
         add(0,0,8'h00,0,0,1,(i % 2 == 0),0, (i == 3 || i == 7),0);
      // 110 with idle gaps
      add(0,1,8'h06,3,1,0,0,1, 0,0);
      add(0,0,8'h00,0,0,1,1,0, 0,0);
      add(0,0,8'h00,0,0,0,0,0, 0,0);
      add(0,0,8'h00,0,0,0,1,0, 0,0);
      add(0,0,8'h00,0,0,1,1,0, 0,0);
      add(0,0,8'h00,0,0,0,0,0, 0,0);
      add(0,0,8'h00,0,0,1,0,0, 1,0);
      add(0,0,8'h00,0,0,0,0,0, 0,0);
      add(0,0,8'h00,0,0,0,0,0, 0,0);
      // rejected loads
      add(0,1,8'hFF,0,1,0,0,0, 0,1);
      add(0,0,8'h00,0,0,0,0,0, 0,0);
      add(0,0,8'h00,0,0,1,1,0, 0,0);
      add(0,1,8'hFF,9,1,0,0,0, 0,1);
      for (int i = 0; i < 4; i++)
         add(0,0,8'h00,0,0,1,1,0, 0,0);
      // reload mid-stream with a beat in the load cycle
      add(0,1,8'h0A,4,1,0,0,1, 0,0);
      add(0,0,8'h00,0,0,1,1,0, 0,0);
      add(0,0,8'h00,0,0,1,0,0, 0,0);
      add(0,0,8'h00,0,0,1,1,0, 0,0);
      add(0,1,8'h03,2,1,1,1,0, 0,0);
      add(0,0,8'h00,0,0,1,1,0, 0,0);
      add(0,0,8'h00,0,0,1,1,0, 1,0);
      add(0,0,8'h00,0,0,1,0,0, 0,0);
      add(0,0,8'h00,0,0,1,1,0, 0,0);
      add(0,0,8'h00,0,0,1,1,0, 1,0);
      // full-length pattern
      p8 = 8'hA5;
      add(0,1,p8,8,0,0,0,1, 0,0);
      for (int i = 7; i >= 0; i--)
         add(0,0,8'h00,0,0,1,p8[i],0, (i == 0),0);
      // len 1: saturation, clear on match, reset with pending match
      add(0,1,8'h01,1,0,0,0,1, 0,0);
      for (int i = 0; i < 8; i++)
         add(0,0,8'h00,0,0,1,1,0, 1,0);
      add(0,0,8'h00,0,0,1,1,1, 1,0);
      add(0,0,8'h00,0,0,1,0,0, 0,0);
      add(0,0,8'h00,0,0,1,1,0, 1,0);
      add(1,0,8'h00,0,0,1,1,0, 0,0);
      add(0,0,8'h00,0,0,1,1,0, 0,0);
      add(0,0,8'h00,0,0,1,1,0, 0,0);

      foreach (tbl[i]) begin
         model(tbl[i], em, ee);
         drive(tbl[i]);
         chk($sformatf("tbl%0d_match", i), int'(match), int'(tbl[i].em));
         chk($sformatf("tbl%0d_err", i), int'(cfg_err), int'(tbl[i].ee));
         chk($sformatf("tbl%0d_cnt", i), int'(match_count), m_cnt);
      end

      for (int n = 0; n < 3000; n++) begin
         v.rst  = ($urandom % 200 == 0);
         v.load = ($urandom % 40 == 0);
         v.pat  = 8'($urandom);
         v.len  = ($urandom % 4 == 0) ? 4'($urandom_range(0, 9))
                                      : 4'($urandom_range(1, 3));
         v.ovl  = 1'($urandom);
         v.vld  = ($urandom % 4 != 0);
         v.b    = 1'($urandom);
         v.clr  = ($urandom % 50 == 0);
         v.em   = 0;
         v.ee   = 0;
         model(v, em, ee);
         drive(v);
         chk("rnd_match", int'(match), int'(em));
         chk("rnd_err", int'(cfg_err), int'(ee));
         chk("rnd_cnt", int'(match_count), m_cnt);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
